// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-requester controller for the 4x4 matrix memory.
// Optional bounds check on the granted base address enabled by MEM_ARB_BOUNDS_EN.
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int MAX_BASE = 85
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              sel,
    output logic              busy,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              gnt;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;

    // On a tie the requester that was not served last wins.
    assign gnt      = (req0 && req1) ? ~last_q : req1;
    assign gnt_we   = gnt ? we1 : we0;
    assign gnt_addr = gnt ? addr1 : addr0;

`ifdef MEM_ARB_BOUNDS_EN
    localparam logic [ADDR_W-1:0] MAX_BASE_C = ADDR_W'(MAX_BASE);
    logic err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        last_d  = last_q;
        addr_d  = addr_q;
`ifdef MEM_ARB_BOUNDS_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    sel_d   = gnt;
                    we_d    = gnt_we;
                    addr_d  = gnt_addr;
                    state_d = ISSUE;
`ifdef MEM_ARB_BOUNDS_EN
                    err_d   = 1'b0;
                    // Out-of-range base skips the memory cycle entirely.
                    if (gnt_addr > MAX_BASE_C) begin
                        err_d   = 1'b1;
                        last_d  = gnt;
                        state_d = RESP;
                    end
`endif
                end
            end
            ISSUE: begin
                last_d  = sel_q;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
`ifdef MEM_ARB_BOUNDS_EN
                err_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
`ifdef MEM_ARB_BOUNDS_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
`ifdef MEM_ARB_BOUNDS_EN
            err_q   <= err_d;
`endif
        end
    end

    assign mem_read  = (state_q == ISSUE) && !we_q;
    assign mem_write = (state_q == ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign sel       = sel_q;
    assign busy      = (state_q != IDLE);
    assign done0     = (state_q == RESP) && !sel_q;
    assign done1     = (state_q == RESP) && sel_q;

`ifdef MEM_ARB_BOUNDS_EN
    assign err0 = err_q && (state_q == RESP) && !sel_q;
    assign err1 = err_q && (state_q == RESP) && sel_q;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus a saturated-contention sequence for mem_arbiter.
`default_nettype none

module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n, req0, we0, req1, we1;
    logic [7:0] addr0, addr1;
    logic       mem_read, mem_write, sel, busy, done0, done1, err0, err1;
    logic [7:0] mem_addr;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.ADDR_W(8), .MAX_BASE(85)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0),
        .req1(req1), .we1(we1), .addr1(addr1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .sel(sel), .busy(busy), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n, req0, we0;
        logic [7:0] addr0;
        logic       req1, we1;
        logic [7:0] addr1;
    } in_t;

    typedef struct packed {
        logic       rd, wr;
        logic [7:0] addr;
        logic       sel, busy, d0, d1, e0, e1;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, q0, w0, input logic [7:0] a0,
                                input logic q1, w1, input logic [7:0] a1,
                                input logic rd, wr, input logic [7:0] ma,
                                input logic s, b, d0, d1, e0, e1);
        vec_t v;
        v.in  = '{r, q0, w0, a0, q1, w1, a1};
        v.exp = '{rd, wr, ma, s, b, d0, d1, e0, e1};
        return v;
    endfunction

    function automatic out_t sample();
        out_t o;
        o = '{mem_read, mem_write, mem_addr, sel, busy, done0, done1, err0, err1};
        return o;
    endfunction

    // Mutual exclusion of read/write strobes, checked every cycle.
    always @(negedge clk) begin
        checks = checks + 1;
        if (mem_read && mem_write) begin
            errors = errors + 1;
            $display("FAIL rw_exclusive: mem_read=%b mem_write=%b required not both 1", mem_read, mem_write);
        end
    end

    initial begin
        out_t act;
        {rst_n, req0, we0, addr0, req1, we1, addr1} = '0;

        //             rst q0 w0 a0     q1 w1 a1      rd wr addr   s b d0 d1 e0 e1
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0,0,0,0,0,0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0,0,0,0,0,0));
        // single read by requester 0
        tbl.push_back(mk(1, 1, 0, 8'h10, 0, 0, 8'h00, 1, 0, 8'h10, 0,1,0,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'h10, 0, 0, 8'h00, 0, 0, 8'h10, 0,1,1,0,0,0));
        tbl.push_back(mk(1, 0, 0, 8'h10, 0, 0, 8'h00, 0, 0, 8'h10, 0,0,0,0,0,0));
        tbl.push_back(mk(1, 0, 0, 8'h10, 0, 0, 8'h00, 0, 0, 8'h10, 0,0,0,0,0,0));
        // single write by requester 1, then read-back by requester 0
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'h20, 0, 1, 8'h20, 1,1,0,0,0,0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'h20, 0, 0, 8'h20, 1,1,0,1,0,0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h20, 0, 0, 8'h20, 1,0,0,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'h20, 0, 0, 8'h00, 1, 0, 8'h20, 0,1,0,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'h20, 0, 0, 8'h00, 0, 0, 8'h20, 0,1,1,0,0,0));
        tbl.push_back(mk(1, 0, 0, 8'h20, 0, 0, 8'h00, 0, 0, 8'h20, 0,0,0,0,0,0));
        // contention from reset: reset dominates, then 0,1,0
        tbl.push_back(mk(0, 1, 0, 8'h30, 1, 1, 8'h40, 0, 0, 8'h00, 0,0,0,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'h30, 1, 1, 8'h40, 1, 0, 8'h30, 0,1,0,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'h30, 1, 1, 8'h40, 0, 0, 8'h30, 0,1,1,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'h30, 1, 1, 8'h40, 0, 0, 8'h30, 0,0,0,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'h30, 1, 1, 8'h40, 0, 1, 8'h40, 1,1,0,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'h30, 1, 1, 8'h40, 0, 0, 8'h40, 1,1,0,1,0,0));
        tbl.push_back(mk(1, 1, 0, 8'h30, 1, 1, 8'h40, 0, 0, 8'h40, 1,0,0,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'h30, 1, 1, 8'h40, 1, 0, 8'h30, 0,1,0,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'h30, 1, 1, 8'h40, 0, 0, 8'h30, 0,1,1,0,0,0));
        tbl.push_back(mk(1, 0, 0, 8'h30, 0, 1, 8'h40, 0, 0, 8'h30, 0,0,0,0,0,0));
        // back-to-back writes by requester 0
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(1, 1, 1, 8'h50, 0, 0, 8'h00, 0, 1, 8'h50, 0,1,0,0,0,0));
            tbl.push_back(mk(1, 1, 1, 8'h50, 0, 0, 8'h00, 0, 0, 8'h50, 0,1,1,0,0,0));
            tbl.push_back(mk(1, k < 2, 1, 8'h50, 0, 0, 8'h00, 0, 0, 8'h50, 0,0,0,0,0,0));
        end
        // reset during ISSUE, then first tie goes to requester 0
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h60, 1, 0, 8'h60, 1,1,0,0,0,0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h60, 0, 0, 8'h00, 0,0,0,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'h70, 1, 0, 8'h60, 1, 0, 8'h70, 0,1,0,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'h70, 1, 0, 8'h60, 0, 0, 8'h70, 0,1,1,0,0,0));
        tbl.push_back(mk(1, 0, 0, 8'h70, 0, 0, 8'h60, 0, 0, 8'h70, 0,0,0,0,0,0));
        // req dropped after grant still completes
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h11, 1, 0, 8'h11, 1,1,0,0,0,0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h11, 0, 0, 8'h11, 1,1,0,1,0,0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h11, 0, 0, 8'h11, 1,0,0,0,0,0));
        // base 86: one past the last legal base
`ifdef MEM_ARB_BOUNDS_EN
        tbl.push_back(mk(1, 1, 0, 8'd86, 0, 0, 8'h00, 0, 0, 8'd86, 0,1,1,0,1,0));
        tbl.push_back(mk(1, 0, 0, 8'd86, 0, 0, 8'h00, 0, 0, 8'd86, 0,0,0,0,0,0));
        tbl.push_back(mk(1, 0, 0, 8'd86, 0, 0, 8'h00, 0, 0, 8'd86, 0,0,0,0,0,0));
`else
        tbl.push_back(mk(1, 1, 0, 8'd86, 0, 0, 8'h00, 1, 0, 8'd86, 0,1,0,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'd86, 0, 0, 8'h00, 0, 0, 8'd86, 0,1,1,0,0,0));
        tbl.push_back(mk(1, 0, 0, 8'd86, 0, 0, 8'h00, 0, 0, 8'd86, 0,0,0,0,0,0));
`endif
        // base 85: last legal base, normal access
        tbl.push_back(mk(1, 1, 0, 8'd85, 0, 0, 8'h00, 1, 0, 8'd85, 0,1,0,0,0,0));
        tbl.push_back(mk(1, 1, 0, 8'd85, 0, 0, 8'h00, 0, 0, 8'd85, 0,1,1,0,0,0));
        tbl.push_back(mk(1, 0, 0, 8'd85, 0, 0, 8'h00, 0, 0, 8'd85, 0,0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            {rst_n, req0, we0, addr0, req1, we1, addr1} = tbl[i].in;
            @(posedge clk);
            #1;
            act = sample();
            checks = checks + 1;
            if (act !== tbl[i].exp) begin
                errors = errors + 1;
                $display("FAIL vec%0d: got rd,wr,addr,sel,busy,d0,d1,e0,e1=%b,%b,%h,%b,%b,%b,%b,%b,%b required %b,%b,%h,%b,%b,%b,%b,%b,%b",
                         i, act.rd, act.wr, act.addr, act.sel, act.busy, act.d0, act.d1, act.e0, act.e1,
                         tbl[i].exp.rd, tbl[i].exp.wr, tbl[i].exp.addr, tbl[i].exp.sel, tbl[i].exp.busy,
                         tbl[i].exp.d0, tbl[i].exp.d1, tbl[i].exp.e0, tbl[i].exp.e1);
            end
        end

        // Saturated contention from reset: done0 at cycles 2,8,..; done1 at 5,11,..
        rst_n = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h02;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            checks = checks + 1;
            if (done0 !== (k % 6 == 2) || done1 !== (k % 6 == 5)) begin
                errors = errors + 1;
                $display("FAIL sat_cycle%0d: done0=%b done1=%b required done0=%b done1=%b",
                         k, done0, done1, (k % 6 == 2), (k % 6 == 5));
            end
        end

        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
